matchstick_game_ctrl: RTL and testbench
=======================================

// Module: matchstick_game_ctrl
// PURPOSE
//  Turn/score controller for the two-player matchsticks game; directly upstream of the 7-seg driver.
//  Holds the pile, validates each player's take and alternates turns; the last-stick taker loses.
//  Drives the driver's pile count, current user, wrong flag and finish flag.
//  Takes raw board buttons and switches, so it synchronises (and optionally debounces) them itself.
// PARAMETERS
//  INIT_STICKS      21          pile size at reset/new game; legal range 1..999 (display shows 3 digits)
//  MAX_TAKE         3           max sticks per move, 1..15
//  WRONG_CYCLES     50_000_000  clocks the wrong flag is held after an illegal move (>=1)
//  DEBOUNCE_CYCLES  500_000     stable clocks needed to accept a button level (DEBOUNCE_EN only)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-high
//  btn_confirm  in   1   raw pushbutton: commit the move on take
//  btn_new      in   1   raw pushbutton: restart the game
//  take         in   4   raw switches: number of sticks to remove
//  sticks       out  16  sticks remaining, plain binary
//  user         out  1   0 = player 1, 1 = player 2; player to move, or the loser when finish=1
//  wrong        out  1   illegal-move indication
//  finish       out  1   game over; the display shows winner 2-user
// BEHAVIOUR
//  - Reset (async) and new-game pulse both force: sticks=INIT_STICKS, user=0, wrong=0, finish=0, state PLAY.
//    Wrong counter cleared.
//  - Input path: btn_confirm, btn_new and take each pass through 2 flops, then btn rise-edge detect
//    (prev-reg; pulse = sync & ~prev, one cycle).
//    take is used as the synced value in the pulse cycle.
//    Latency, no debounce: input high before edge k -> pulse in cycle after k+1 -> outputs change at edge k+2.
//  - FSM states: PLAY, WRONG, DONE. All outputs registered.
//  - PLAY, confirm pulse, legal move (1 <= take <= MAX_TAKE and take <= sticks):
//    - sticks <= sticks - take.
//    - If the result is 0: go to DONE, finish=1, user unchanged (the taker loses).
//    - Otherwise: user toggles and stay in PLAY.
//  - PLAY, confirm pulse, illegal move (take=0, take>MAX_TAKE, or take>sticks):
//    - go to WRONG, wrong=1, counter loaded with WRONG_CYCLES-1; sticks and user unchanged.
//  - WRONG: counter decrements each clock. At counter==0: wrong=0, return to PLAY.
//    wrong is high for exactly WRONG_CYCLES clocks.
//    Confirm pulses in WRONG are ignored and not queued.
//  - DONE: confirm ignored; outputs hold until btn_new or rst.
//  - btn_new pulse wins over a simultaneous confirm pulse, in any state including WRONG mid-count.
//  - Subtraction is 16-bit unsigned. take is zero-extended. The take<=sticks check prevents underflow.
//  - A held button produces a single move; it must be released (sync low) before the next pulse.
// CONFIGURATION
//  MATCHSTICK_DEBOUNCE_EN
//  - Defined: after the 2-flop sync, each button has a debounce counter.
//    - The debounced level flips only after the synced input has differed from it for DEBOUNCE_CYCLES
//      consecutive clocks; any bounce restarts the count.
//    - The edge detect runs on the debounced level. This adds DEBOUNCE_CYCLES clocks of latency.
//    - take is not debounced.
//  - Not defined: no debounce logic; edge detect runs directly on the synced level.
// TESTING  (INIT_STICKS=5, MAX_TAKE=3, WRONG_CYCLES=4, macro undefined unless stated)
//  1 Assert rst mid-game, async -> sticks=5, user=0, wrong=0, finish=0 before the next clk edge.
//  2 take=2 confirm -> sticks=3, user=1; take=3 confirm -> sticks=0, finish=1, user=1 (player 2 lost).
//  3 take=0 confirm -> wrong=1 for exactly 4 clocks, then 0.
//    sticks=5 and user=0 unchanged; a confirm during wrong has no effect.
//  4 Play to sticks=2, then take=3 confirm -> wrong (exceeds pile). Then take=4 at full pile -> wrong (exceeds MAX_TAKE).
//  5 In DONE, btn_new and btn_confirm rise in the same cycle -> sticks=5, user=0, finish=0; no move applied.
//  6 Macro defined, DEBOUNCE_CYCLES=8: 3-clock confirm glitch -> no change.
//    12-clock press with take=1 -> exactly one move, sticks 5->4.

Source files
------------

// File: rtl/matchstick_game_ctrl_if.sv
// Button/switch inputs and display outputs of the matchsticks game controller.
// master: board/bench side driving raw inputs; slave: the controller.
interface matchstick_game_ctrl_if;
    logic        btn_confirm;
    logic        btn_new;
    logic [3:0]  take;
    logic [15:0] sticks;
    logic        user;
    logic        wrong;
    logic        finish;

    modport master (
        output btn_confirm, btn_new, take,
        input  sticks, user, wrong, finish
    );

    modport slave (
        input  btn_confirm, btn_new, take,
        output sticks, user, wrong, finish
    );
endinterface

// File: rtl/matchstick_game_ctrl.sv
// Turn/score controller for the two-player matchsticks game.
// Holds the pile, validates each take, alternates players; the last-stick taker loses.
// Raw buttons/switches are synchronised here; button debounce is added when
// MATCHSTICK_DEBOUNCE_EN is defined (take is never debounced).
//
// state | meaning
// PLAY  | waiting for a confirm from the player in 'user'
// WRONG | illegal move shown, wrong held for WRONG_CYCLES clocks, confirms ignored
// DONE  | pile empty, 'user' is the loser, waits for new game
module matchstick_game_ctrl #(
    parameter int INIT_STICKS     = 21,
    parameter int MAX_TAKE        = 3,
    parameter int WRONG_CYCLES    = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic                  clk,
    input  logic                  rst,
    matchstick_game_ctrl_if.slave bus
);

    localparam int WCW = (WRONG_CYCLES > 1) ? $clog2(WRONG_CYCLES) : 1;
    localparam logic [3:0]     MAX_TAKE_L   = 4'(MAX_TAKE);
    localparam logic [15:0]    INIT_L       = 16'(INIT_STICKS);
    localparam logic [WCW-1:0] WRONG_LOAD_L = WCW'(WRONG_CYCLES - 1);

    if (INIT_STICKS < 1 || INIT_STICKS > 999) begin : g_bad_init
        $error("INIT_STICKS out of range 1..999");
    end
    if (MAX_TAKE < 1 || MAX_TAKE > 15) begin : g_bad_max
        $error("MAX_TAKE out of range 1..15");
    end
    if (WRONG_CYCLES < 1) begin : g_bad_wrong
        $error("WRONG_CYCLES must be >= 1");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("DEBOUNCE_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {PLAY, WRONG, DONE} state_t;

    logic       confirm_s1, confirm_s2, new_s1, new_s2;
    logic [3:0] take_s1, take_s2;
    logic       confirm_lvl, new_lvl, confirm_prev, new_prev;
    logic       confirm_pulse, new_pulse;

    // Two-flop synchronisers for the raw board inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            confirm_s1 <= 1'b0;
            confirm_s2 <= 1'b0;
            new_s1     <= 1'b0;
            new_s2     <= 1'b0;
            take_s1    <= 4'd0;
            take_s2    <= 4'd0;
        end else begin
            confirm_s1 <= bus.btn_confirm;
            confirm_s2 <= confirm_s1;
            new_s1     <= bus.btn_new;
            new_s2     <= new_s1;
            take_s1    <= bus.take;
            take_s2    <= take_s1;
        end
    end

`ifdef MATCHSTICK_DEBOUNCE_EN
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LOAD_L = DBW'(DEBOUNCE_CYCLES - 1);

    logic           confirm_db, new_db;
    logic [DBW-1:0] confirm_cnt, new_cnt;

    // Debounce: the accepted level flips only after DEBOUNCE_CYCLES consecutive
    // disagreeing clocks; any agreeing clock reloads the down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            confirm_db  <= 1'b0;
            new_db      <= 1'b0;
            confirm_cnt <= DB_LOAD_L;
            new_cnt     <= DB_LOAD_L;
        end else begin
            if (confirm_s2 == confirm_db) begin
                confirm_cnt <= DB_LOAD_L;
            end else if (confirm_cnt == '0) begin
                confirm_db  <= confirm_s2;
                confirm_cnt <= DB_LOAD_L;
            end else begin
                confirm_cnt <= confirm_cnt - 1'b1;
            end

            if (new_s2 == new_db) begin
                new_cnt <= DB_LOAD_L;
            end else if (new_cnt == '0) begin
                new_db  <= new_s2;
                new_cnt <= DB_LOAD_L;
            end else begin
                new_cnt <= new_cnt - 1'b1;
            end
        end
    end

    assign confirm_lvl = confirm_db;
    assign new_lvl     = new_db;
`else
    assign confirm_lvl = confirm_s2;
    assign new_lvl     = new_s2;
`endif

    // Previous-level registers for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            confirm_prev <= 1'b0;
            new_prev     <= 1'b0;
        end else begin
            confirm_prev <= confirm_lvl;
            new_prev     <= new_lvl;
        end
    end

    assign confirm_pulse = confirm_lvl & ~confirm_prev;
    assign new_pulse     = new_lvl & ~new_prev;

    state_t         state;
    logic [15:0]    sticks_q;
    logic           user_q, wrong_q, finish_q;
    logic [WCW-1:0] wrong_cnt;
    logic [15:0]    take_ext;
    logic           legal;

    assign take_ext = {12'd0, take_s2};
    assign legal    = (take_s2 != 4'd0) && (take_s2 <= MAX_TAKE_L) && (take_ext <= sticks_q);

    // Game FSM; new-game pulse overrides everything, including a WRONG countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PLAY;
            sticks_q  <= INIT_L;
            user_q    <= 1'b0;
            wrong_q   <= 1'b0;
            finish_q  <= 1'b0;
            wrong_cnt <= '0;
        end else if (new_pulse) begin
            state     <= PLAY;
            sticks_q  <= INIT_L;
            user_q    <= 1'b0;
            wrong_q   <= 1'b0;
            finish_q  <= 1'b0;
            wrong_cnt <= '0;
        end else begin
            case (state)
                PLAY: begin
                    if (confirm_pulse) begin
                        if (legal) begin
                            sticks_q <= sticks_q - take_ext;
                            if (take_ext == sticks_q) begin
                                finish_q <= 1'b1;
                                state    <= DONE;
                            end else begin
                                user_q <= ~user_q;
                            end
                        end else begin
                            wrong_q   <= 1'b1;
                            wrong_cnt <= WRONG_LOAD_L;
                            state     <= WRONG;
                        end
                    end
                end
                WRONG: begin
                    if (wrong_cnt == '0) begin
                        wrong_q <= 1'b0;
                        state   <= PLAY;
                    end else begin
                        wrong_cnt <= wrong_cnt - 1'b1;
                    end
                end
                DONE: begin
                end
                default: state <= PLAY;
            endcase
        end
    end

    assign bus.sticks = sticks_q;
    assign bus.user   = user_q;
    assign bus.wrong  = wrong_q;
    assign bus.finish = finish_q;

endmodule

// File: tb/tb_matchstick_game_ctrl.sv
// Directed bench for matchstick_game_ctrl (INIT_STICKS=5, MAX_TAKE=3, WRONG_CYCLES=4).
// With MATCHSTICK_DEBOUNCE_EN defined only the debounce scenario runs (DEBOUNCE_CYCLES=8).
module tb_matchstick_game_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    matchstick_game_ctrl_if gif();

    matchstick_game_ctrl #(
        .INIT_STICKS    (5),
        .MAX_TAKE       (3),
        .WRONG_CYCLES   (4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(gif.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive buttons/take at a falling edge, hold for 'hold' clocks, release, settle 3 clocks.
    task automatic press(input logic c, input logic n, input logic [3:0] t, input int hold);
        @(negedge clk);
        gif.take        = t;
        gif.btn_confirm = c;
        gif.btn_new     = n;
        repeat (hold) @(negedge clk);
        gif.btn_confirm = 1'b0;
        gif.btn_new     = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input int s, input int u, input int w, input int f);
        chk({tag, "_sticks"}, int'(gif.sticks), s);
        chk({tag, "_user"},   int'(gif.user),   u);
        chk({tag, "_wrong"},  int'(gif.wrong),  w);
        chk({tag, "_finish"}, int'(gif.finish), f);
    endtask

    initial begin
        int wrong_len;
        rst             = 1'b1;
        gif.btn_confirm = 1'b0;
        gif.btn_new     = 1'b0;
        gif.take        = 4'd0;
        repeat (3) @(negedge clk);
        chk_out("reset", 5, 0, 0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifdef MATCHSTICK_DEBOUNCE_EN
        // 3-clock glitch is shorter than the debounce window
        press(1'b1, 1'b0, 4'd1, 3);
        repeat (20) @(negedge clk);
        chk_out("glitch", 5, 0, 0, 0);
        // 12-clock press gives exactly one move
        press(1'b1, 1'b0, 4'd1, 12);
        repeat (20) @(negedge clk);
        chk_out("db_press", 4, 1, 0, 0);
`else
        // Latency: set before edge 1, unchanged after edge 2, applied at edge 3
        @(negedge clk);
        gif.take        = 4'd2;
        gif.btn_confirm = 1'b1;
        repeat (2) @(negedge clk);
        chk("lat_e2_sticks", int'(gif.sticks), 5);
        @(negedge clk);
        chk("lat_e3_sticks", int'(gif.sticks), 3);
        chk("lat_e3_user", int'(gif.user), 1);
        gif.btn_confirm = 1'b0;
        repeat (3) @(negedge clk);

        // Player 2 takes the last three and loses
        press(1'b1, 1'b0, 4'd3, 3);
        chk_out("lose", 0, 1, 0, 1);
        press(1'b1, 1'b0, 4'd1, 3);
        chk_out("done_ignore", 0, 1, 0, 1);

        // New game and confirm together in DONE: new wins, no move
        press(1'b1, 1'b1, 4'd1, 3);
        chk_out("new_vs_conf", 5, 0, 0, 0);

        // take=0 -> wrong for exactly 4 clocks; second confirm mid-wrong ignored
        wrong_len = 0;
        @(negedge clk);
        gif.take        = 4'd0;
        gif.btn_confirm = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (gif.wrong) wrong_len++;
            if (i == 2) gif.btn_confirm = 1'b0;
            if (i == 3) begin
                gif.take        = 4'd1;
                gif.btn_confirm = 1'b1;
            end
            if (i == 5) gif.btn_confirm = 1'b0;
        end
        chk("wrong_len", wrong_len, 4);
        chk_out("after_wrong", 5, 0, 0, 0);

        // Pile 2, take 3 exceeds pile
        press(1'b1, 1'b0, 4'd3, 3);
        chk_out("to_two", 2, 1, 0, 0);
        press(1'b1, 1'b0, 4'd3, 3);
        chk_out("over_pile", 2, 1, 1, 0);
        repeat (3) @(negedge clk);
        chk("over_pile_clr", int'(gif.wrong), 0);

        // Full pile, take 4 exceeds MAX_TAKE
        press(1'b0, 1'b1, 4'd0, 3);
        chk_out("newgame", 5, 0, 0, 0);
        press(1'b1, 1'b0, 4'd4, 3);
        chk_out("over_max", 5, 0, 1, 0);
        repeat (3) @(negedge clk);

        // New game during a WRONG countdown
        press(1'b1, 1'b0, 4'd1, 3);
        chk_out("pre_mid", 4, 1, 0, 0);
        @(negedge clk);
        gif.take        = 4'd0;
        gif.btn_confirm = 1'b1;
        @(negedge clk);
        gif.btn_confirm = 1'b0;
        gif.btn_new     = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_wrong_on", int'(gif.wrong), 1);
        @(negedge clk);
        chk_out("mid_new", 5, 0, 0, 0);
        gif.btn_new = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_new_stay", int'(gif.wrong), 0);

        // Held button: one move only
        press(1'b1, 1'b0, 4'd1, 10);
        chk_out("held", 4, 1, 0, 0);

        // Asynchronous reset mid-game, visible before the next clock edge
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_out("async_rst", 5, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_out("post_rst", 5, 0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
